// File: rtl/ft_async_tx.sv
// Transmit half of the FT2232H asynchronous 245-FIFO interface: buffers bytes
// from the uP side and drains them with timed WR_N strobes while TXE_N allows.
module ft_async_tx #(
  parameter int unsigned DATA        = 8,
  parameter int unsigned ADDR        = 4,
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned PULSE_CYC   = 6,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned RECOVER_CYC = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ext_wr,
  input  logic [DATA-1:0] ext_wr_data,
  output logic            ext_wr_full,
  output logic            ext_wr_overflow,
  output logic            ft_busy,
  input  logic            TXE_N,
  output logic            WR_N,
  output logic [DATA-1:0] ft_wr_data,
  output logic            ft_wr_oe
);

  localparam int unsigned DEPTH = 1 << ADDR;
  localparam int unsigned CW    = ADDR + 1;
  localparam int unsigned TW    = 8;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     tmr, tmr_nxt;
  logic              txe_m, txe_s;
  logic [DATA-1:0]   mem [DEPTH];
  logic [ADDR-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_nxt;
  logic              push_ok, pop;
  logic              wr_n_nxt, oe_nxt, busy_nxt;
  logic [DATA-1:0]   data_nxt;

  // Space check uses the registered count only; a same-cycle pop frees nothing.
  assign push_ok = ext_wr && (count < CW'(DEPTH));

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if ((count != '0) && !txe_s) begin
          pop       = 1'b1;
          state_nxt = SETUP;
          tmr_nxt   = TW'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (tmr == '0) begin
          state_nxt = STROBE;
          tmr_nxt   = TW'(PULSE_CYC - 1);
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end
      STROBE: begin
        if (tmr == '0) begin
          state_nxt = HOLD;
          tmr_nxt   = TW'(HOLD_CYC - 1);
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end
      HOLD: begin
        if (tmr == '0) begin
          state_nxt = RECOVER;
          tmr_nxt   = TW'(RECOVER_CYC - 1);
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end
      RECOVER: begin
        if (tmr == '0) begin
          state_nxt = IDLE;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        tmr_nxt   = '0;
      end
    endcase

    unique case ({push_ok, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase

    // Outputs are registered from the next state so they align with it.
    wr_n_nxt = (state_nxt != STROBE);
    oe_nxt   = (state_nxt == SETUP) || (state_nxt == STROBE) || (state_nxt == HOLD);
    busy_nxt = (state_nxt != IDLE);
    data_nxt = pop ? mem[rd_ptr] : ft_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      tmr             <= '0;
      txe_m           <= 1'b1;
      txe_s           <= 1'b1;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      ext_wr_full     <= 1'b0;
      ext_wr_overflow <= 1'b0;
      ft_busy         <= 1'b0;
      WR_N            <= 1'b1;
      ft_wr_oe        <= 1'b0;
      ft_wr_data      <= '0;
    end else begin
      state           <= state_nxt;
      tmr             <= tmr_nxt;
      txe_m           <= TXE_N;
      txe_s           <= txe_m;
      count           <= count_nxt;
      ext_wr_full     <= (count_nxt == CW'(DEPTH));
      ext_wr_overflow <= ext_wr && !push_ok;
      ft_busy         <= busy_nxt;
      WR_N            <= wr_n_nxt;
      ft_wr_oe        <= oe_nxt;
      ft_wr_data      <= data_nxt;
      if (push_ok) wr_ptr <= wr_ptr + ADDR'(1);
      if (pop)     rd_ptr <= rd_ptr + ADDR'(1);
    end
  end

  // Storage array carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= ext_wr_data;
  end

endmodule

// File: tb/tb_ft_async_tx.sv
// Scoreboard bench for ft_async_tx: accepted pushes queue expected bytes,
// a negedge monitor pops and checks them at every WR_N falling edge.
module tb_ft_async_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       ext_wr;
  logic [7:0] ext_wr_data;
  logic       ext_wr_full, ext_wr_overflow, ft_busy;
  logic       TXE_N, WR_N;
  logic [7:0] ft_wr_data;
  logic       ft_wr_oe;

  ft_async_tx dut (
    .clk(clk), .rst(rst), .ext_wr(ext_wr), .ext_wr_data(ext_wr_data),
    .ext_wr_full(ext_wr_full), .ext_wr_overflow(ext_wr_overflow),
    .ft_busy(ft_busy), .TXE_N(TXE_N), .WR_N(WR_N),
    .ft_wr_data(ft_wr_data), .ft_wr_oe(ft_wr_oe)
  );

  always #5 clk = ~clk;

  int         errors = 0, checks = 0;
  logic [7:0] exp_q[$];
  logic       ovf_exp = 1'b0, rej_pend = 1'b0;
  int         cyc = 0, strobe_cnt = 0, low_cnt = 0, oe_len = 0;
  int         oe_rise_cyc = 0, last_fall = -1;
  logic       prev_wr_n = 1'b1, prev_oe = 1'b0, burst_on = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: strobe shape, data order and overflow pulse, sampled at negedge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_wr_n = 1'b1;
      prev_oe   = 1'b0;
      low_cnt   = 0;
      oe_len    = 0;
    end else begin
      check("ovf", int'(ext_wr_overflow), int'(ovf_exp));
      if (prev_wr_n && !WR_N) begin
        strobe_cnt++;
        check("setup", cyc - oe_rise_cyc, 1);
        check("oe_at_strobe", int'(ft_wr_oe), 1);
        if (exp_q.size() == 0) check("spurious_strobe", int'(WR_N), 1);
        else check("data", int'(ft_wr_data), int'(exp_q.pop_front()));
        if (burst_on && last_fall >= 0) check("spacing", cyc - last_fall, 12);
        last_fall = cyc;
      end
      if (!WR_N) low_cnt++;
      else if (!prev_wr_n) begin
        check("pulse_w", low_cnt, 6);
        low_cnt = 0;
      end
      if (ft_wr_oe) begin
        if (!prev_oe) oe_rise_cyc = cyc;
        oe_len++;
      end else if (prev_oe) begin
        check("oe_len", oe_len, 8);
        oe_len = 0;
      end
      prev_wr_n = WR_N;
      prev_oe   = ft_wr_oe;
    end
  end

  // One cycle of stimulus; an accepted push is queued, a rejected one arms ovf_exp.
  task automatic step(input logic wr, input logic [7:0] d);
    @(posedge clk); #1;
    ovf_exp     = rej_pend;
    ext_wr      = wr;
    ext_wr_data = d;
    rej_pend    = wr && (exp_q.size() >= 16);
    if (wr && !rej_pend) exp_q.push_back(d);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic wait_drain(input int max);
    int k = 0;
    while ((exp_q.size() != 0 || ft_busy) && k < max) begin
      step(1'b0, 8'h00);
      k++;
    end
    check("drain_q", exp_q.size(), 0);
    check("drain_busy", int'(ft_busy), 0);
  endtask

  task automatic wait_wr_low(input int max);
    int k = 0;
    while (WR_N && k < max) begin
      step(1'b0, 8'h00);
      k++;
    end
    check("wr_low_seen", int'(WR_N), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, seen, n;
    rst = 1'b1; ext_wr = 1'b0; ext_wr_data = 8'h00; TXE_N = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_wr_n", int'(WR_N), 1);
    check("rst_oe", int'(ft_wr_oe), 0);
    check("rst_data", int'(ft_wr_data), 0);
    check("rst_full", int'(ext_wr_full), 0);
    check("rst_busy", int'(ft_busy), 0);

    step(1'b0, 8'h00);
    TXE_N = 1'b0;
    idle(4);

    // Single byte
    s0 = strobe_cnt;
    step(1'b1, 8'hA5);
    wait_drain(60);
    check("single_strobes", strobe_cnt - s0, 1);
    check("single_full", int'(ext_wr_full), 0);

    // Burst of 16
    burst_on = 1'b1; last_fall = -1; s0 = strobe_cnt;
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i));
    wait_drain(300);
    burst_on = 1'b0;
    check("burst_strobes", strobe_cnt - s0, 16);
    idle(2);

    // Overflow while TXE_N holds off the FT side
    step(1'b0, 8'h00);
    TXE_N = 1'b1;
    idle(4);
    s0 = strobe_cnt;
    for (int i = 0; i < 15; i++) step(1'b1, 8'(8'h21 + i));
    step(1'b0, 8'h00);
    @(negedge clk);
    check("full_15", int'(ext_wr_full), 0);
    step(1'b1, 8'h30);
    step(1'b0, 8'h00);
    @(negedge clk);
    check("full_16", int'(ext_wr_full), 1);
    step(1'b1, 8'h31);
    idle(3);
    check("full_17", int'(ext_wr_full), 1);
    check("no_wr_txe1", strobe_cnt - s0, 0);
    step(1'b0, 8'h00);
    TXE_N = 1'b0;
    wait_drain(400);
    check("ovf_drained", strobe_cnt - s0, 16);
    idle(20);

    // Flow control: TXE_N rises mid-strobe
    s0 = strobe_cnt;
    step(1'b1, 8'h11);
    step(1'b1, 8'h12);
    step(1'b0, 8'h00);
    wait_wr_low(30);
    TXE_N = 1'b1;
    n = 0;
    while (!WR_N && n < 20) begin
      step(1'b0, 8'h00);
      n++;
    end
    idle(2);
    seen = 0;
    repeat (25) begin
      step(1'b0, 8'h00);
      if (ft_wr_oe || !WR_N) seen++;
    end
    check("txe_block", seen, 0);
    check("busy_blocked", int'(ft_busy), 0);
    check("fc_one_strobe", strobe_cnt - s0, 1);
    step(1'b0, 8'h00);
    TXE_N = 1'b0;
    n = 0;
    while (!ft_wr_oe && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("resume_lat", n, 3);
    wait_drain(60);
    check("fc_two_strobes", strobe_cnt - s0, 2);

    // Reset mid-transfer
    step(1'b1, 8'h55);
    step(1'b1, 8'h66);
    step(1'b0, 8'h00);
    wait_wr_low(30);
    s0 = strobe_cnt;
    rst = 1'b1; ovf_exp = 1'b0; rej_pend = 1'b0;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mrst_wr_n", int'(WR_N), 1);
    check("mrst_oe", int'(ft_wr_oe), 0);
    check("mrst_data", int'(ft_wr_data), 0);
    check("mrst_busy", int'(ft_busy), 0);
    check("mrst_full", int'(ext_wr_full), 0);
    idle(40);
    check("no_strobe_after_rst", strobe_cnt - s0, 0);
    step(1'b1, 8'h77);
    wait_drain(60);
    check("post_rst_strobe", strobe_cnt - s0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
